// File: rtl/rv32i_instr_encoder_pkg.sv
// Shared RV32I encoding definitions: opcodes, op classes, funct3 constants, command payloads.
// Imported by the instruction encoder and by the decode controller.
package rv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned OP_W  = 4;

    localparam logic [6:0] R_OP      = 7'h33;
    localparam logic [6:0] I_OP      = 7'h13;
    localparam logic [6:0] I_LOAD_OP = 7'h03;
    localparam logic [6:0] STORE_OP  = 7'h23;
    localparam logic [6:0] BRANCH_OP = 7'h63;
    localparam logic [6:0] JAL_OP    = 7'h6F;
    localparam logic [6:0] JALR_OP   = 7'h67;
    localparam logic [6:0] LUI_OP    = 7'h37;
    localparam logic [6:0] AUIPC_OP  = 7'h17;

    typedef enum logic [OP_W-1:0] {
        OPC_R      = 4'd0,
        OPC_I      = 4'd1,
        OPC_LOAD   = 4'd2,
        OPC_STORE  = 4'd3,
        OPC_BRANCH = 4'd4,
        OPC_JAL    = 4'd5,
        OPC_JALR   = 4'd6,
        OPC_LUI    = 4'd7,
        OPC_AUIPC  = 4'd8
    } op_class_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SRX  = 3'b101;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [F3_W-1:0]  funct3;
        logic             alt;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [XLEN-1:0]  imm;
    } cmd_t;

    typedef struct packed {
        logic            illegal;
        logic [XLEN-1:0] word;
    } enc_t;

    // True when v is representable as a signed value of the given bit count.
    function automatic logic fits_signed(input logic [XLEN-1:0] v, input int unsigned bits);
        logic [XLEN-1:0] mask;
        logic [XLEN-1:0] upper;
        mask  = 32'hFFFF_FFFF << (bits - 1);
        upper = v & mask;
        return (upper == '0) || (upper == mask);
    endfunction

    function automatic logic is_branch_f3(input logic [F3_W-1:0] f3);
        return (f3 == F3_BEQ) || (f3 == F3_BNE) || (f3 == F3_BLT) ||
               (f3 == F3_BGE) || (f3 == F3_BLTU) || (f3 == F3_BGEU);
    endfunction

endpackage

// File: rtl/rv32i_instr_encoder_fifo.sv
// Synchronous FIFO with registered storage and occupancy count.
// The head entry is presented directly; push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/rv32i_instr_encoder.sv
// RV32I instruction encoder: turns field-level commands into machine words, rejects illegal
// commands, and streams the legal words out of a FIFO with sequential word addresses.
module rv32i_instr_encoder
    import rv_pkg::*;
#(
    parameter int unsigned    DEPTH     = 4,
    parameter int unsigned    AW        = 32,
    parameter logic [AW-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [2:0]        cmd_funct3,
    input  logic              cmd_alt,
    input  logic [4:0]        cmd_rd,
    input  logic [4:0]        cmd_rs1,
    input  logic [4:0]        cmd_rs2,
    input  logic [31:0]       cmd_imm,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr_word,
    output logic [AW-1:0]     instr_addr,
    output logic              err,
    output logic [7:0]        err_count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    // Field packing and legality for one command; word is don't-care when illegal.
    function automatic enc_t encode(input cmd_t c);
        enc_t       r;
        logic       alt_ok;
        logic       is_shift;
        logic [6:0] funct7;
        r.illegal = 1'b0;
        r.word    = '0;
        alt_ok    = 1'b0;
        funct7    = {1'b0, c.alt, 5'b0};
        is_shift  = (c.funct3 == F3_SLL) || (c.funct3 == F3_SRX);
        case (c.op)
            OPC_R: begin
                r.word = {funct7, c.rs2, c.rs1, c.funct3, c.rd, R_OP};
                alt_ok = (c.funct3 == F3_ADD) || (c.funct3 == F3_SRX);
            end
            OPC_I: begin
                if (is_shift) begin
                    r.word = {funct7, c.imm[4:0], c.rs1, c.funct3, c.rd, I_OP};
                    if (|c.imm[31:5]) r.illegal = 1'b1;
                end else begin
                    r.word = {c.imm[11:0], c.rs1, c.funct3, c.rd, I_OP};
                    if (!fits_signed(c.imm, 12)) r.illegal = 1'b1;
                end
                alt_ok = (c.funct3 == F3_SRX);
            end
            OPC_LOAD: begin
                r.word = {c.imm[11:0], c.rs1, c.funct3, c.rd, I_LOAD_OP};
                if (!fits_signed(c.imm, 12) || c.funct3 == 3'b011 ||
                    c.funct3 == 3'b110 || c.funct3 == 3'b111) r.illegal = 1'b1;
            end
            OPC_STORE: begin
                r.word = {c.imm[11:5], c.rs2, c.rs1, c.funct3, c.imm[4:0], STORE_OP};
                if (!fits_signed(c.imm, 12) || c.funct3 >= 3'b011) r.illegal = 1'b1;
            end
            OPC_BRANCH: begin
                r.word = {c.imm[12], c.imm[10:5], c.rs2, c.rs1, c.funct3,
                          c.imm[4:1], c.imm[11], BRANCH_OP};
                if (!fits_signed(c.imm, 13) || c.imm[0] || !is_branch_f3(c.funct3))
                    r.illegal = 1'b1;
            end
            OPC_JAL: begin
                r.word = {c.imm[20], c.imm[10:1], c.imm[11], c.imm[19:12], c.rd, JAL_OP};
                if (!fits_signed(c.imm, 21) || c.imm[0]) r.illegal = 1'b1;
            end
            OPC_JALR: begin
                r.word = {c.imm[11:0], c.rs1, c.funct3, c.rd, JALR_OP};
                if (!fits_signed(c.imm, 12) || c.funct3 != 3'b000) r.illegal = 1'b1;
            end
            OPC_LUI: begin
                r.word = {c.imm[31:12], c.rd, LUI_OP};
                if (|c.imm[11:0]) r.illegal = 1'b1;
            end
            OPC_AUIPC: begin
                r.word = {c.imm[31:12], c.rd, AUIPC_OP};
                if (|c.imm[11:0]) r.illegal = 1'b1;
            end
            default: r.illegal = 1'b1;
        endcase
        if (c.alt && !alt_ok) r.illegal = 1'b1;
        return r;
    endfunction

    cmd_t          cmd;
    enc_t          enc;
    logic          accept;
    logic          pop;
    logic          push;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    always_comb begin
        cmd        = '0;
        cmd.op     = cmd_op;
        cmd.funct3 = cmd_funct3;
        cmd.alt    = cmd_alt;
        cmd.rd     = cmd_rd;
        cmd.rs1    = cmd_rs1;
        cmd.rs2    = cmd_rs2;
        cmd.imm    = cmd_imm;
        enc        = encode(cmd);
    end

    // Readiness follows committed occupancy only, so a same-cycle pop never frees a slot.
    assign cmd_ready   = (fifo_count != CW'(DEPTH));
    assign accept      = cmd_valid && cmd_ready;
    assign push        = accept && !enc.illegal && !fifo_full;
    assign instr_valid = !fifo_empty;
    assign pop         = instr_valid && instr_ready;

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (enc.word),
        .rdata (instr_word),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Head address tracks pops; rejected commands never reach the FIFO so consume no address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_addr <= BASE_ADDR;
        end else if (pop) begin
            instr_addr <= instr_addr + AW'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            err <= accept && enc.illegal;
            if (accept && enc.illegal && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Directed self-checking bench for rv32i_instr_encoder (DEPTH=4, AW=32, BASE_ADDR=0).
module tb_rv32i_instr_encoder;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [2:0]  cmd_funct3;
    logic        cmd_alt;
    logic [4:0]  cmd_rd;
    logic [4:0]  cmd_rs1;
    logic [4:0]  cmd_rs2;
    logic [31:0] cmd_imm;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_word;
    logic [31:0] instr_addr;
    logic        err;
    logic [7:0]  err_count;

    int          vectors;
    int          miscompares;
    logic [31:0] exp_addr;
    int          exp_errs;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  f3;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] word;
    } vec_t;

    always #5 clk = ~clk;

    rv32i_instr_encoder #(
        .DEPTH     (4),
        .AW        (32),
        .BASE_ADDR (BASE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_funct3  (cmd_funct3),
        .cmd_alt     (cmd_alt),
        .cmd_rd      (cmd_rd),
        .cmd_rs1     (cmd_rs1),
        .cmd_rs2     (cmd_rs2),
        .cmd_imm     (cmd_imm),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_word  (instr_word),
        .instr_addr  (instr_addr),
        .err         (err),
        .err_count   (err_count)
    );

    function automatic logic [31:0] addi_word(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd0, 3'd0, rd, 7'h13};
    endfunction

    task automatic drive_cmd(input logic [3:0] op, input logic [2:0] f3, input logic alt,
                             input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [31:0] imm);
        cmd_op     = op;
        cmd_funct3 = f3;
        cmd_alt    = alt;
        cmd_rd     = rd;
        cmd_rs1    = rs1;
        cmd_rs2    = rs2;
        cmd_imm    = imm;
    endtask

    // Present one command until accepted; returns #1 after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [2:0] f3, input logic alt,
                        input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
        int n;
        drive_cmd(op, f3, alt, rd, rs1, rs2, imm);
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!cmd_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: cmd_ready got %b want 1", cmd_ready);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        instr_ready = 1'b0;
        drive_cmd(4'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        vectors++; if (instr_word !== 32'd0) begin miscompares++; $display("FAIL rst_word: got %h want 0", instr_word); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b want 0", err); end
        vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL rst_err_count: got %0d want 0", err_count); end
        vectors++; if (instr_addr !== BASE) begin miscompares++; $display("FAIL rst_addr: got %h want %h", instr_addr, BASE); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
        exp_addr = BASE;
        exp_errs = 0;
    endtask

    task automatic test_encode();
        vec_t v[$];
        v.push_back('{4'd0, 3'd0, 1'b0, 5'd3,  5'd1,  5'd2, 32'd0,          32'h002081B3});
        v.push_back('{4'd0, 3'd0, 1'b1, 5'd5,  5'd6,  5'd7, 32'd0,          32'h407302B3});
        v.push_back('{4'd1, 3'd0, 1'b0, 5'd1,  5'd0,  5'd9, 32'hFFFF_FFFF,  32'hFFF00093});
        v.push_back('{4'd4, 3'd0, 1'b0, 5'd7,  5'd1,  5'd2, 32'd8,          32'h00208463});
        v.push_back('{4'd5, 3'd0, 1'b0, 5'd1,  5'd0,  5'd0, 32'd2048,       32'h001000EF});
        v.push_back('{4'd7, 3'd0, 1'b0, 5'd2,  5'd0,  5'd0, 32'h1234_5000,  32'h12345137});
        v.push_back('{4'd3, 3'd2, 1'b0, 5'd31, 5'd10, 5'd5, 32'hFFFF_FFFC,  32'hFE552E23});
        v.push_back('{4'd1, 3'd5, 1'b1, 5'd1,  5'd2,  5'd0, 32'd3,          32'h40315093});
        v.push_back('{4'd8, 3'd0, 1'b0, 5'd4,  5'd0,  5'd0, 32'hFFFF_F000,  32'hFFFFF217});
        v.push_back('{4'd6, 3'd0, 1'b0, 5'd1,  5'd5,  5'd0, 32'd4,          32'h004280E7});
        v.push_back('{4'd4, 3'd1, 1'b0, 5'd0,  5'd1,  5'd2, 32'hFFFF_FFFC,  32'hFE209EE3});
        v.push_back('{4'd2, 3'd4, 1'b0, 5'd3,  5'd4,  5'd0, 32'd2047,       32'h7FF24183});
        v.push_back('{4'd5, 3'd0, 1'b0, 5'd0,  5'd0,  5'd0, 32'hFFFF_FFFE,  32'hFFFFF06F});
        v.push_back('{4'd4, 3'd0, 1'b0, 5'd0,  5'd0,  5'd0, 32'hFFFF_F000,  32'h80000063});
        foreach (v[i]) begin
            send(v[i].op, v[i].f3, v[i].alt, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm);
            vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL enc[%0d] valid: got %b want 1", i, instr_valid); end
            vectors++; if (instr_word !== v[i].word) begin miscompares++; $display("FAIL enc[%0d] word: got %h want %h", i, instr_word, v[i].word); end
            vectors++; if (instr_addr !== exp_addr) begin miscompares++; $display("FAIL enc[%0d] addr: got %h want %h", i, instr_addr, exp_addr); end
            vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL enc[%0d] err: got %b want 0", i, err); end
            instr_ready = 1'b1;
            @(posedge clk);
            #1;
            instr_ready = 1'b0;
            exp_addr = exp_addr + 32'd4;
            vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL enc[%0d] drained: got %b want 0", i, instr_valid); end
        end
    endtask

    task automatic test_illegal();
        vec_t v[$];
        v.push_back('{4'd4,  3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3,         32'd0});
        v.push_back('{4'd9,  3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0,         32'd0});
        v.push_back('{4'd15, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0,         32'd0});
        v.push_back('{4'd1,  3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 32'd2048,      32'd0});
        v.push_back('{4'd1,  3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 32'hFFFF_F7FF, 32'd0});
        v.push_back('{4'd1,  3'd1, 1'b0, 5'd1, 5'd1, 5'd0, 32'd32,        32'd0});
        v.push_back('{4'd7,  3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h1234_5001, 32'd0});
        v.push_back('{4'd0,  3'd1, 1'b1, 5'd1, 5'd1, 5'd1, 32'd0,         32'd0});
        v.push_back('{4'd1,  3'd0, 1'b1, 5'd1, 5'd1, 5'd0, 32'd1,         32'd0});
        v.push_back('{4'd2,  3'd3, 1'b0, 5'd1, 5'd1, 5'd0, 32'd0,         32'd0});
        v.push_back('{4'd2,  3'd6, 1'b0, 5'd1, 5'd1, 5'd0, 32'd0,         32'd0});
        v.push_back('{4'd3,  3'd3, 1'b0, 5'd0, 5'd1, 5'd2, 32'd0,         32'd0});
        v.push_back('{4'd6,  3'd1, 1'b0, 5'd1, 5'd1, 5'd0, 32'd0,         32'd0});
        v.push_back('{4'd5,  3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1,         32'd0});
        v.push_back('{4'd5,  3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0010_0000, 32'd0});
        v.push_back('{4'd4,  3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,         32'd0});
        v.push_back('{4'd4,  3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4096,      32'd0});
        foreach (v[i]) begin
            send(v[i].op, v[i].f3, v[i].alt, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm);
            exp_errs++;
            vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL ill[%0d] err: got %b want 1", i, err); end
            vectors++; if (err_count !== 8'(exp_errs)) begin miscompares++; $display("FAIL ill[%0d] err_count: got %0d want %0d", i, err_count, exp_errs); end
            vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL ill[%0d] pushed: got %b want 0", i, instr_valid); end
            @(posedge clk);
            #1;
            vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL ill[%0d] err_pulse: got %b want 0", i, err); end
        end
        send(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1);
        vectors++; if (instr_word !== 32'h00100093) begin miscompares++; $display("FAIL post_err word: got %h want 00100093", instr_word); end
        vectors++; if (instr_addr !== exp_addr) begin miscompares++; $display("FAIL post_err addr: got %h want %h", instr_addr, exp_addr); end
        instr_ready = 1'b1;
        @(posedge clk);
        #1;
        instr_ready = 1'b0;
        exp_addr = exp_addr + 32'd4;
    endtask

    task automatic test_back_to_back();
        logic [31:0] q[$];
        int          next_i;
        int          popped;
        int          guard;
        logic        do_push;
        logic        do_pop;
        instr_ready = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_cmd(4'd1, 3'd0, 1'b0, 5'(i + 1), 5'd0, 5'd0, 32'(i));
            @(posedge clk);
            #1;
            q.push_back(addi_word(5'(i + 1), 12'(i)));
            vectors++; if (cmd_ready !== (i < 3)) begin miscompares++; $display("FAIL b2b cmd_ready[%0d]: got %b want %b", i, cmd_ready, (i < 3)); end
        end
        next_i = 4;
        drive_cmd(4'd1, 3'd0, 1'b0, 5'(next_i + 1), 5'd0, 5'd0, 32'(next_i));
        instr_ready = 1'b1;
        vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL full_pop cmd_ready: got %b want 0", cmd_ready); end
        popped = 0;
        guard = 0;
        while (popped < 6 && guard < 40) begin
            do_push = cmd_valid && cmd_ready;
            do_pop = instr_valid && instr_ready;
            if (do_pop) begin
                vectors++; if (instr_word !== q[0]) begin miscompares++; $display("FAIL b2b word[%0d]: got %h want %h", popped, instr_word, q[0]); end
                vectors++; if (instr_addr !== exp_addr) begin miscompares++; $display("FAIL b2b addr[%0d]: got %h want %h", popped, instr_addr, exp_addr); end
                void'(q.pop_front());
                exp_addr = exp_addr + 32'd4;
                popped++;
            end
            @(posedge clk);
            #1;
            if (do_push) begin
                q.push_back(addi_word(5'(next_i + 1), 12'(next_i)));
                next_i++;
                if (next_i == 6) cmd_valid = 1'b0;
                else drive_cmd(4'd1, 3'd0, 1'b0, 5'(next_i + 1), 5'd0, 5'd0, 32'(next_i));
            end
            guard++;
        end
        instr_ready = 1'b0;
        cmd_valid = 1'b0;
        vectors++; if (popped !== 6) begin miscompares++; $display("FAIL b2b popped: got %0d want 6", popped); end
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL b2b leftover: got %b want 0", instr_valid); end
    endtask

    task automatic test_push_pop_same_cycle();
        logic [31:0] want;
        instr_ready = 1'b0;
        send(4'd1, 3'd0, 1'b0, 5'd10, 5'd0, 5'd0, 32'd10);
        send(4'd1, 3'd0, 1'b0, 5'd11, 5'd0, 5'd0, 32'd11);
        drive_cmd(4'd1, 3'd0, 1'b0, 5'd12, 5'd0, 5'd0, 32'd12);
        cmd_valid = 1'b1;
        instr_ready = 1'b1;
        @(posedge clk);
        #1;
        instr_ready = 1'b0;
        exp_addr = exp_addr + 32'd4;
        vectors++; if (instr_word !== addi_word(5'd11, 12'd11)) begin miscompares++; $display("FAIL pp head: got %h want %h", instr_word, addi_word(5'd11, 12'd11)); end
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL pp occ2 cmd_ready: got %b want 1", cmd_ready); end
        drive_cmd(4'd1, 3'd0, 1'b0, 5'd13, 5'd0, 5'd0, 32'd13);
        @(posedge clk);
        #1;
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL pp occ3 cmd_ready: got %b want 1", cmd_ready); end
        drive_cmd(4'd1, 3'd0, 1'b0, 5'd14, 5'd0, 5'd0, 32'd14);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL pp occ4 cmd_ready: got %b want 0", cmd_ready); end
        instr_ready = 1'b1;
        for (int k = 11; k <= 14; k++) begin
            want = addi_word(5'(k), 12'(k));
            vectors++; if (instr_word !== want) begin miscompares++; $display("FAIL pp drain word[%0d]: got %h want %h", k, instr_word, want); end
            vectors++; if (instr_addr !== exp_addr) begin miscompares++; $display("FAIL pp drain addr[%0d]: got %h want %h", k, instr_addr, exp_addr); end
            @(posedge clk);
            #1;
            exp_addr = exp_addr + 32'd4;
        end
        instr_ready = 1'b0;
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL pp empty: got %b want 0", instr_valid); end
    endtask

    task automatic test_async_reset();
        instr_ready = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_cmd(4'd1, 3'd0, 1'b0, 5'(20 + i), 5'd0, 5'd0, 32'(20 + i));
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL arst pre valid: got %b want 1", instr_valid); end
        vectors++; if (err_count !== 8'(exp_errs)) begin miscompares++; $display("FAIL arst pre err_count: got %0d want %0d", err_count, exp_errs); end
        #2;
        rst = 1'b1;
        #1;
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL arst valid: got %b want 0", instr_valid); end
        vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL arst err_count: got %0d want 0", err_count); end
        vectors++; if (instr_addr !== BASE) begin miscompares++; $display("FAIL arst addr: got %h want %h", instr_addr, BASE); end
        vectors++; if (instr_word !== 32'd0) begin miscompares++; $display("FAIL arst word: got %h want 0", instr_word); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_addr = BASE;
        exp_errs = 0;
        send(4'd1, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'd7);
        vectors++; if (instr_word !== addi_word(5'd7, 12'd7)) begin miscompares++; $display("FAIL arst new word: got %h want %h", instr_word, addi_word(5'd7, 12'd7)); end
        vectors++; if (instr_addr !== BASE) begin miscompares++; $display("FAIL arst new addr: got %h want %h", instr_addr, BASE); end
        vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL arst post err_count: got %0d want 0", err_count); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        exp_addr = BASE;
        exp_errs = 0;
        test_reset();
        test_encode();
        test_illegal();
        test_back_to_back();
        test_push_pop_same_cycle();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
